aximm_burst_seq: RTL
====================

AXIMM_BURST_SEQ -- requirements
Module: aximm_burst_seq

Interface
REQ-001 SHALL have parameter DATA_WBITS, default 512: AXI4 write-data width in bits; DATA_WBYTS = DATA_WBITS/8.
REQ-002 SHALL have parameter MAX_BURST_BEATS, default 64: maximum beats per burst, legal range 1..256.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that launches a transfer.
REQ-006 SHALL have port cfg_addr  input  64  start byte address, DATA_WBYTS-aligned.
REQ-007 SHALL have port cfg_bytes  input  32  total byte count.
REQ-008 SHALL have port busy  output  1  high from the accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port error  output  1  sticky: a non-OKAY BRESP was seen during the current or most recent transfer.
REQ-011 SHALL have port M_AXI_AWADDR  output  64  burst address.
REQ-012 SHALL have port M_AXI_AWLEN  output  8  beats minus 1.
REQ-013 SHALL have port M_AXI_AWSIZE  output  3  constant $clog2(DATA_WBYTS); AWBURST tie-off is INCR.
REQ-014 SHALL have port M_AXI_AWVALID / M_AXI_AWREADY  output/input  1  AW handshake.
REQ-015 SHALL have port M_AXI_WDATA  output  DATA_WBITS  write data.
REQ-016 SHALL have port M_AXI_WSTRB  output  DATA_WBYTS  byte strobes.
REQ-017 SHALL have port M_AXI_WLAST  output  1  last beat of the burst.
REQ-018 SHALL have port M_AXI_WVALID / M_AXI_WREADY  output/input  1  W handshake.
REQ-019 SHALL have port M_AXI_BRESP  input  2  write response.
REQ-020 SHALL have port M_AXI_BVALID / M_AXI_BREADY  input/output  1  BREADY is constant 1.

Function
REQ-021 SHALL implement FSM states IDLE, CALC, XFER, WAIT_B, DONE.
REQ-022 IDLE: on start, latch cfg_addr and cfg_bytes, clear error, set busy, go to CALC; if cfg_bytes==0, go to DONE instead with no bus activity.
REQ-023 SHALL ignore start in every state other than IDLE.
REQ-024 CALC (1 cycle): beats = min(remaining beats, MAX_BURST_BEATS, beats to next 4 KB boundary); remaining beats = ceil(remaining bytes / DATA_WBYTS); then load AWADDR and AWLEN=beats-1, assert AWVALID and WVALID, go to XFER.
REQ-025 XFER: AWVALID SHALL be held until the AWREADY handshake; W beats SHALL proceed independently of AW acceptance; WLAST SHALL be high only on the burst's final beat and only while WVALID is high.
REQ-026 On the WLAST handshake: drop WVALID and advance the address by beats*DATA_WBYTS; go to CALC if bytes remain, otherwise go to WAIT_B.
REQ-027 SHALL NOT leave XFER before AWVALID has been accepted.
REQ-028 WDATA SHALL be the transfer-global beat number (32-bit, first beat 0), zero-extended.
REQ-029 WSTRB SHALL be all ones, except on the final beat of the transfer when cfg_bytes mod DATA_WBYTS = e != 0, where it SHALL be (1<<e)-1.
REQ-030 SHALL keep an outstanding-burst counter: +1 on AW handshake, -1 on B handshake, unchanged when both occur in the same cycle.
REQ-031 WAIT_B SHALL exit to DONE when the counter is 0.
REQ-032 DONE SHALL pulse done for 1 cycle, clear busy, and return to IDLE.
REQ-033 Any B handshake with BRESP != 0 SHALL set error; error SHALL hold until the next accepted start.

Reset
REQ-034 While resetn==0, SHALL force: state IDLE, AWVALID=0, WVALID=0, busy=0, done=0, error=0, outstanding counter 0, AWADDR=0, AWLEN=0.
REQ-035 Reset during XFER or WAIT_B SHALL abandon the transfer; all valids SHALL be 0 on the first cycle after reset.

Verification (DATA_WBITS=512, MAX_BURST_BEATS=64)
REQ-036 addr 0x1000, bytes 128 -> 1 AW: addr 0x1000, AWLEN=1; 2 beats with WDATA 0,1 and full WSTRB; done 1 cycle after BVALID.
REQ-037 addr 0x1000, bytes 100 -> AWLEN=1; last WSTRB = 64'h0000000FFFFFFFFF.
REQ-038 addr 0x0FC0, bytes 256 -> AW 0x0FC0 with AWLEN=0, then AW 0x1000 with AWLEN=2; WDATA 0..3.
REQ-039 addr 0, bytes 8320 -> AWs at 0x0 (AWLEN 63), 0x1000 (AWLEN 63), 0x2000 (AWLEN 1); AWREADY held low 10 cycles on burst 2 keeps AWVALID high; done only after all 3 B responses.
REQ-040 BRESP=2 on burst 2 of REQ-039 -> error=1 at done; next start clears error to 0.
REQ-041 resetn low mid-XFER -> AWVALID=WVALID=busy=0 next cycle; a subsequent start works normally.

Source files
------------

// File: rtl/aximm_burst_seq.sv
// AXI4 write-burst sequencer: splits a linear transfer into INCR bursts
// that respect MAX_BURST_BEATS and 4 KB boundaries, writing a beat counter.
module aximm_burst_seq #(
    parameter int DATA_WBITS      = 512,
    parameter int MAX_BURST_BEATS = 64,
    localparam int DATA_WBYTS     = DATA_WBITS / 8,
    localparam int LOG2_BYTS      = $clog2(DATA_WBYTS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [63:0]           cfg_addr,
    input  logic [31:0]           cfg_bytes,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [63:0]           M_AXI_AWADDR,
    output logic [7:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_WBITS-1:0] M_AXI_WDATA,
    output logic [DATA_WBYTS-1:0] M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_XFER, S_WAIT_B, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] beat_q, beat_d;
    logic [8:0]  left_q, left_d;
    logic [8:0]  outst_q, outst_d;
    logic [63:0] awaddr_q, awaddr_d;
    logic [7:0]  awlen_q, awlen_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        aw_hs, w_hs, b_hs, wlast;
    logic [32:0] rem_beats, to_4k, beats;

    assign aw_hs = awvalid_q & M_AXI_AWREADY;
    assign w_hs  = wvalid_q & M_AXI_WREADY;
    assign b_hs  = M_AXI_BVALID;
    assign wlast = wvalid_q & (left_q == 9'd1);

    always_comb begin
        rem_beats = ({1'b0, rem_q} + 33'(DATA_WBYTS - 1)) >> LOG2_BYTS;
        to_4k = 33'((13'd4096 - {1'b0, addr_q[11:0]}) >> LOG2_BYTS);
        beats = rem_beats;
        if (beats > 33'(MAX_BURST_BEATS)) beats = 33'(MAX_BURST_BEATS);
        if (beats > to_4k) beats = to_4k;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        beat_d    = beat_q;
        left_d    = left_q;
        outst_d   = outst_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;

        if (aw_hs && !b_hs) outst_d = outst_q + 9'd1;
        else if (!aw_hs && b_hs && outst_q != 9'd0)
            outst_d = outst_q - 9'd1;
        if (b_hs && M_AXI_BRESP != 2'b00) err_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = cfg_addr;
                    rem_d  = cfg_bytes;
                    beat_d = 32'd0;
                    err_d  = 1'b0;
                    if (cfg_bytes == 32'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_CALC: begin
                awaddr_d  = addr_q;
                awlen_d   = 8'(beats - 33'd1);
                left_d    = 9'(beats);
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                state_d   = S_XFER;
            end
            S_XFER: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs) begin
                    beat_d = beat_q + 32'd1;
                    left_d = left_q - 9'd1;
                    rem_d  = (rem_q > 32'(DATA_WBYTS))
                           ? rem_q - 32'(DATA_WBYTS) : 32'd0;
                    if (wlast) begin
                        wvalid_d = 1'b0;
                        addr_d = addr_q
                               + ((64'(awlen_q) + 64'd1) << LOG2_BYTS);
                    end
                end
                // Leave only once both the AW and the whole W burst are gone.
                if ((!awvalid_q || aw_hs) && (!wvalid_q || (w_hs && wlast)))
                    state_d = (rem_d != 32'd0) ? S_CALC : S_WAIT_B;
            end
            S_WAIT_B: begin
                if (outst_d == 9'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            addr_q    <= 64'd0;
            rem_q     <= 32'd0;
            beat_q    <= 32'd0;
            left_q    <= 9'd0;
            outst_q   <= 9'd0;
            awaddr_q  <= 64'd0;
            awlen_q   <= 8'd0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            beat_q    <= beat_d;
            left_q    <= left_d;
            outst_q   <= outst_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Bytes left before this beat decide its strobe: a short tail on the end.
    always_comb begin
        for (int i = 0; i < DATA_WBYTS; i++)
            M_AXI_WSTRB[i] = (rem_q > 32'(i));
    end

    assign M_AXI_WDATA   = {{(DATA_WBITS-32){1'b0}}, beat_q};
    assign M_AXI_WLAST   = wlast;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = awlen_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_AWSIZE  = 3'(LOG2_BYTS);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_BREADY  = 1'b1;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = err_q;

endmodule
